regfile_operand_stage: RTL and testbench
========================================

# regfile_operand_stage

Register-file and operand-issue stage sitting directly upstream of the 32-bit `add` datapath. It holds the 32 architectural registers, reads the `rs`/`rt` operands for each issued instruction into an output holding register, and presents them to the adder with a valid/ready handshake. The adder's `rd` result returns through a write-back port. A per-register busy scoreboard stalls issue on read-after-write and write-after-write hazards.

## Interface
- `DATA_W`, 32, register and operand width.
- `ADDR_W`, 5, register address width; the register count is 2^ADDR_W, and register 0 is hardwired to zero.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `issue_valid`  in  1  an instruction is offered.
- `issue_ready`  out  1  the stage accepts the instruction this cycle.
- `rs_addr`, `rt_addr`, `rd_addr`  in  ADDR_W  source and destination register numbers.
- `op_valid`  out  1  operands are valid toward the adder.
- `op_ready`  in  1  the adder consumes the operands this cycle.
- `rs_data`, `rt_data`  out  DATA_W  signed operands fed to the adder.
- `op_rd_addr`  out  ADDR_W  destination that travels with the operands.
- `wb_valid`  in  1  write-back strobe from the adder stage.
- `wb_addr`  in  ADDR_W  write-back register.
- `wb_data`  in  DATA_W  write-back value (the adder's `rd`).

## Operation
- Issue fires when `issue_valid && issue_ready`. Handshakes on the output side use the same valid/ready convention.
- `issue_ready = (!op_valid || op_ready) && !hazard`.
  - `hazard` is true when `busy[rs_addr]`, `busy[rt_addr]` or `busy[rd_addr]` is set.
  - The hazard is cleared for any of those addresses equal to `wb_addr` while `wb_valid` is high in the same cycle.
  - Register 0 never contributes to `hazard`.
- On fire:
  - Register `rs_data`/`rt_data` from the register file.
  - If `wb_valid` is high and `wb_addr` matches a source, bypass `wb_data` into that operand.
  - A source address of 0 always yields 0.
  - Latch `op_rd_addr`, set `op_valid`, and set `busy[rd_addr]` when `rd_addr != 0`.
- When `op_valid && op_ready` with no new fire, clear `op_valid`. Data outputs hold their last value.
- While `op_valid && !op_ready`, `rs_data`, `rt_data` and `op_rd_addr` stay stable.
- Write-back: when `wb_valid` is high and `wb_addr != 0`:
  - Write `wb_data` and clear `busy[wb_addr]`.
  - A write to a non-busy register is legal: it updates the data and leaves busy at 0.
  - `wb_valid` to register 0 is ignored.
- Simultaneous fire and write-back to the same register as `rd_addr`: the data is written and busy ends at 1, because set wins over clear.
- Arithmetic: the stage performs none. Operands pass through bit-exact, and signedness is the adder's concern.

## Timing
- Reset (asynchronous, `rst_n` = 0): all registers 0, all busy bits 0, `op_valid` 0, `rs_data`/`rt_data`/`op_rd_addr` 0. `issue_ready` is combinationally 1 during reset.
- Issue-to-operand latency is 1 cycle: fire at edge N gives `op_valid` = 1 after edge N.
- Write-back is visible to an issue in the same cycle via the bypass. The register array updates at the same edge.
- Throughput is 1 instruction/cycle with `op_ready` held high and no hazards.
- A dependent instruction stalls until the cycle in which its producer's `wb_valid` arrives, then fires in that cycle using the bypass.
- `issue_ready` is combinational from the addresses, `busy`, `wb_*`, `op_valid` and `op_ready`. `op_valid` and all data outputs are registered.
- Reset asserted mid-operation: `op_valid` and busy bits drop immediately and any in-flight write-back is lost. After release, the first fire can occur at the first rising edge.

## Test plan
- Reset then idle:
  - Required: all outputs 0 and `issue_ready` = 1.
  - Stimulus: issue rs=0, rt=0, rd=0.
  - Required: `rs_data` = `rt_data` = 0, `op_valid` = 1 one cycle later, no busy bit set.
- Write-back then read:
  - Stimulus: wb r3=0x1C71C71C and r4=0x1C71C71C, then issue rs=3, rt=4, rd=5.
  - Required: both operands 0x1C71C71C, `op_rd_addr` = 5, `busy[5]` = 1.
- RAW stall and bypass:
  - Stimulus: issue rs=1, rt=2, rd=6, then issue rs=6, rt=1, rd=7.
  - Required: `issue_ready` stays 0 until `wb_valid` with r6=0xFFFFFFFB. The dependent instruction then fires in that cycle with `rs_data` = 0xFFFFFFFB.
- Backpressure:
  - Stimulus: hold `op_ready` = 0 for 3 cycles after an issue with rs=3, then raise it.
  - Required: operands stable for all 3 cycles, `issue_ready` = 0 throughout, one transfer on release.
- Register 0:
  - Stimulus: wb r0=0xFFFFFFFF, then issue rs=0, rt=0.
  - Required: operands 0. An issue with rd=0 never stalls a later reader of r0.
- Set-wins collision:
  - Stimulus: with r8 busy, in one cycle send wb r8=0x80000000 and issue rs=8, rt=0, rd=8.
  - Required: `rs_data` = 0x80000000 and `busy[8]` = 1 afterwards.
- Mid-operation reset:
  - Stimulus: assert `rst_n` = 0 while `op_valid` = 1.
  - Required: `op_valid` = 0 immediately, and operands read 0 for every register on the next issue.

Source files
------------

// File: rtl/regfile_operand_stage.sv
// Register file and operand-issue stage feeding the add datapath.
// Holds the architectural registers, a busy scoreboard and a registered operand output.
module regfile_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [ADDR_W-1:0] op_rd_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [DATA_W-1:0]  regs_q [NumRegs];
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               op_valid_q;
  logic [DATA_W-1:0]  rs_data_q, rt_data_q, rs_data_d, rt_data_d;
  logic [ADDR_W-1:0]  op_rd_addr_q;

  logic wb_en, fire, hazard;
  logic rs_haz, rt_haz, rd_haz;

  always_comb begin
    wb_en = wb_valid && (wb_addr != '0);
    // A write-back arriving this cycle releases the matching source/destination.
    rs_haz = (rs_addr != '0) && busy_q[rs_addr] && !(wb_valid && (wb_addr == rs_addr));
    rt_haz = (rt_addr != '0) && busy_q[rt_addr] && !(wb_valid && (wb_addr == rt_addr));
    rd_haz = (rd_addr != '0) && busy_q[rd_addr] && !(wb_valid && (wb_addr == rd_addr));
    hazard = rs_haz || rt_haz || rd_haz;
    issue_ready = (!op_valid_q || op_ready) && !hazard;
    fire = issue_valid && issue_ready;
  end

  always_comb begin
    rs_data_d = '0;
    rt_data_d = '0;
    if (rs_addr != '0) begin
      rs_data_d = (wb_valid && (wb_addr == rs_addr)) ? wb_data : regs_q[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_data_d = (wb_valid && (wb_addr == rt_addr)) ? wb_data : regs_q[rt_addr];
    end
  end

  // Clear first so a same-cycle set for the new destination wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (fire && (rd_addr != '0)) begin
      busy_d[rd_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      op_valid_q   <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      op_rd_addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (fire) begin
        op_valid_q   <= 1'b1;
        rs_data_q    <= rs_data_d;
        rt_data_q    <= rt_data_d;
        op_rd_addr_q <= rd_addr;
      end else if (op_ready) begin
        op_valid_q <= 1'b0;
      end
    end
  end

  assign op_valid   = op_valid_q;
  assign rs_data    = rs_data_q;
  assign rt_data    = rt_data_q;
  assign op_rd_addr = op_rd_addr_q;

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench for regfile_operand_stage: reference model plus operand scoreboard.
module tb_regfile_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  op_rd_addr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  regfile_operand_stage #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .op_rd_addr (op_rd_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_ov;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic busy_of(input logic [4:0] a, input logic wv, input logic [4:0] wa);
    return (a != 5'd0) && m_busy[a] && !(wv && (wa == a));
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic wv,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wv && (wa == a)) return wd;
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_busy = 32'd0;
    m_ov   = 1'b0;
    sb.delete();
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model.
  task automatic cycle(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wv, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ordy);
    logic exp_rdy, fire;
    exp_t e;
    issue_valid = iv;
    rs_addr     = rs;
    rt_addr     = rt;
    rd_addr     = rd;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
    op_ready    = ordy;
    exp_rdy = (!m_ov || ordy) && !(busy_of(rs, wv, wa) || busy_of(rt, wv, wa) ||
                                   busy_of(rd, wv, wa));
    fire = iv && exp_rdy;
    @(negedge clk);
    check("issue_ready", {31'd0, issue_ready}, {31'd0, exp_rdy});
    check("op_valid", {31'd0, op_valid}, {31'd0, m_ov});
    if (m_ov && (sb.size() != 0)) begin
      e = sb[0];
      check("rs_data", rs_data, e.rs);
      check("rt_data", rt_data, e.rt);
      check("op_rd_addr", {27'd0, op_rd_addr}, {27'd0, e.rd});
      if (ordy) void'(sb.pop_front());
    end
    if (fire) begin
      e.rs = operand(rs, wv, wa, wd);
      e.rt = operand(rt, wv, wa, wd);
      e.rd = rd;
      sb.push_back(e);
    end
    if (wv && (wa != 5'd0)) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (fire && (rd != 5'd0)) m_busy[rd] = 1'b1;
    if (fire) m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    rs_addr     = '0;
    rt_addr     = '0;
    rd_addr     = '0;
    op_ready    = 1'b0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    model_clear();

    #3;
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_rs_data", rs_data, 32'd0);
    check("rst_rt_data", rt_data, 32'd0);
    check("rst_op_rd_addr", {27'd0, op_rd_addr}, 32'd0);
    check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset then idle: r0-only issue, then a further r0 issue must not stall.
    idle();
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    idle();

    // Write-back then read; r5 then becomes busy and is released via bypass.
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h1C71C71C, 1'b1);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h1C71C71C, 1'b1);
    cycle(1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 5'd5, 32'h12345678, 1'b1);
    idle();

    // RAW stall and bypass.
    cycle(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd6, 5'd1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd6, 5'd1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd6, 5'd1, 5'd7, 1'b1, 5'd6, 32'hFFFFFFFB, 1'b1);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h00000042, 1'b1);
    idle();

    // Backpressure for 3 cycles, then one transfer plus the pending issue.
    cycle(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    idle();

    // Register 0 ignores writes and never creates a hazard.
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h00000009, 1'b1);
    idle();

    // Set-wins collision on r8, then a reader of r8 must stall.
    cycle(1'b1, 5'd1, 5'd0, 5'd8, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 5'd8, 32'h80000000, 1'b1);
    cycle(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);

    // Mid-operation reset while operands are held.
    cycle(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    issue_valid = 1'b1;
    rs_addr     = 5'd8;
    rt_addr     = 5'd3;
    rd_addr     = 5'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_op_valid", {31'd0, op_valid}, 32'd0);
    check("midrst_rs_data", rs_data, 32'd0);
    check("midrst_rt_data", rt_data, 32'd0);
    check("midrst_issue_ready", {31'd0, issue_ready}, 32'd1);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, i[4:0], i[4:0], 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
